// File: rtl/trigger_conditioner_pkg.sv
// Shared types and defaults for the trigger conditioner.
package trigger_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARM_HIGH = 2'd1,
      PRESSED  = 2'd2,
      ARM_LOW  = 2'd3
   } trig_state_t;

   localparam int TRIG_SYNC_STAGES_DEF = 2;
   localparam int TRIG_DEBOUNCE_DEF    = 16;
   localparam int TRIG_COUNT_W         = 8;

endpackage

// File: rtl/trigger_conditioner_sync_chain.sv
// N-flop synchroniser for an asynchronous level; q_o is the last stage.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d_i};
      end
   end

   assign q_o = ff[STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// Synchronise, debounce and latch a raw button press for the CPU trigger input.
// Optional press counter built only when TRIG_EVENT_COUNT_EN is defined.
module trigger_conditioner
   import trigger_pkg::*;
#(
   parameter int SYNC_STAGES     = TRIG_SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = TRIG_DEBOUNCE_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    trigger_raw_i,
   input  logic                    ack_i,
   output logic                    trigger_o,
   output logic                    pulse_o,
   output logic                    overrun_o,
   output logic [TRIG_COUNT_W-1:0] count_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic              sync;
   trig_state_t       state;
   trig_state_t       state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              press_evt;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (trigger_raw_i),
      .q_o   (sync)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A press is accepted only on the ARM_HIGH -> PRESSED edge; returning
   // from ARM_LOW to PRESSED is just release bounce and is not an event.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_evt = 1'b0;
      case (state)
         IDLE: begin
            if (sync) begin
               state_nxt = ARM_HIGH;
               cnt_nxt   = '0;
            end
         end
         ARM_HIGH: begin
            if (!sync) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = PRESSED;
               press_evt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!sync) begin
               state_nxt = ARM_LOW;
               cnt_nxt   = '0;
            end
         end
         ARM_LOW: begin
            if (sync) begin
               state_nxt = PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ack_i is a one-cycle strobe with no ready; a press in the same cycle
   // wins, keeping trigger_o set while still clearing the overrun flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pulse_o   <= 1'b0;
         trigger_o <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         pulse_o <= press_evt;
         if (press_evt) begin
            trigger_o <= 1'b1;
            overrun_o <= ack_i ? 1'b0 : (overrun_o | trigger_o);
         end else if (ack_i) begin
            trigger_o <= 1'b0;
            overrun_o <= 1'b0;
         end
      end
   end

`ifdef TRIG_EVENT_COUNT_EN
   logic [TRIG_COUNT_W-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (press_evt) begin
         count_q <= count_q + TRIG_COUNT_W'(1);
      end
   end

   assign count_o = count_q;
`else
   assign count_o = '0;
`endif

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner with S=2, D=4.
module tb_trigger_conditioner;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       trigger_raw_i = 1'b0;
   logic       ack_i = 1'b0;
   logic       trigger_o;
   logic       pulse_o;
   logic       overrun_o;
   logic [7:0] count_o;

   int n_vec = 0;
   int n_miss = 0;
   int n_press = 0;

   typedef struct {
      logic       raw;
      logic       ack;
      logic       pulse;
      logic       trig;
      logic       ovr;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[20];
   logic pat[7];

   trigger_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .trigger_raw_i (trigger_raw_i),
      .ack_i         (ack_i),
      .trigger_o     (trigger_o),
      .pulse_o       (pulse_o),
      .overrun_o     (overrun_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_cnt(input int n);
`ifdef TRIG_EVENT_COUNT_EN
      return 8'(n);
`else
      return 8'h00;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input logic ep, input logic et,
                            input logic eo, input logic [7:0] ec);
      n_vec++;
      if (pulse_o !== ep || trigger_o !== et || overrun_o !== eo || count_o !== ec) begin
         n_miss++;
         $display("FAIL %s: got pulse=%0b trig=%0b ovr=%0b cnt=%0d, expected pulse=%0b trig=%0b ovr=%0b cnt=%0d",
                  name, pulse_o, trigger_o, overrun_o, count_o, ep, et, eo, ec);
      end
   endtask

   task automatic check_pulse(input string name, input logic ep);
      n_vec++;
      if (pulse_o !== ep) begin
         n_miss++;
         $display("FAIL %s: got pulse=%0b, expected pulse=%0b", name, pulse_o, ep);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      trigger_raw_i = 1'b0;
      ack_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
      n_press = 0;
   endtask

   // Raw held high from IDLE: event lands after the 7th edge (index 6).
   task automatic press(input string name, input logic ack_at_evt, input logic exp_ovr);
      trigger_raw_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ack_i = ack_at_evt && (i == 6);
         tick();
         if (i == 6) begin
            n_press++;
            check_all(name, 1'b1, 1'b1, exp_ovr, exp_cnt(n_press));
         end else begin
            check_pulse(name, 1'b0);
         end
      end
      ack_i = 1'b0;
   endtask

   task automatic release_btn(input string name);
      trigger_raw_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_pulse(name, 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < 20; i++) begin
         tbl[i].raw   = 1'b1;
         tbl[i].ack   = (i == 15);
         tbl[i].pulse = (i == 6);
         tbl[i].trig  = (i >= 6) && (i < 15);
         tbl[i].ovr   = 1'b0;
         tbl[i].cnt   = exp_cnt((i >= 6) ? 1 : 0);
      end
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset state
      do_reset();
      check_all("reset_state", 1'b0, 1'b0, 1'b0, 8'h00);

      // Clean press then ack at cycle 15
      for (int i = 0; i < 20; i++) begin
         trigger_raw_i = tbl[i].raw;
         ack_i = tbl[i].ack;
         tick();
         check_all($sformatf("clean_vec%0d", i), tbl[i].pulse, tbl[i].trig, tbl[i].ovr, tbl[i].cnt);
      end
      ack_i = 1'b0;
      release_btn("clean_release");

      // Ack with nothing pending has no effect
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check_all("ack_idle", 1'b0, 1'b0, 1'b0, exp_cnt(1));

      // Overrun then press/ack collision
      do_reset();
      press("ovr_press1", 1'b0, 1'b0);
      release_btn("ovr_release1");
      press("ovr_press2", 1'b0, 1'b1);
      release_btn("ovr_release2");
      press("collide_press3", 1'b1, 1'b0);
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check_all("ack_after_collide", 1'b0, 1'b0, 1'b0, exp_cnt(3));
      release_btn("collide_release");

      // Bounce: runs of 1 never long enough, then hold high
      do_reset();
      for (int i = 0; i < 45; i++) begin
         trigger_raw_i = (i < 30) ? pat[i % 7] : 1'b1;
         tick();
         check_all($sformatf("bounce_%0d", i), (i == 34), (i >= 34), 1'b0,
                   exp_cnt((i >= 34) ? 1 : 0));
      end
      release_btn("bounce_release");

      // Reset mid-debounce at edge 4
      do_reset();
      for (int i = 0; i < 16; i++) begin
         trigger_raw_i = 1'b1;
         rst_i = (i == 4);
         tick();
         check_all($sformatf("rst_mid_%0d", i), (i == 11), (i >= 11), 1'b0,
                   exp_cnt((i >= 11) ? 1 : 0));
      end
      rst_i = 1'b0;
      n_press = 1;
      release_btn("rst_mid_release");

      // Counter wrap after 256 presses
      for (int k = 0; k < 255; k++) begin
         press($sformatf("wrap_press%0d", k + 2), 1'b0, 1'b1);
         release_btn("wrap_release");
      end
      check_all("wrap_final", 1'b0, 1'b1, 1'b1, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
